// File: rtl/raster_pkg.sv
// -----------------------------------------------------------------------------
// raster_pkg
// Shared types and helpers for the triangle rasteriser.
//   state_t      : scan controller states
//   edge_width() : width of a signed edge accumulator for a given coordinate
//                  width. It is wide enough that the edge value never overflows
//                  anywhere inside the bounding box.
//   EDGE_W       : accumulator width for the default 8-bit coordinates
//   edge_t       : signed edge value at the default width
//   covered()    : inclusive inside test. Its inputs are the sign of the
//                  twice-area and the sign/zero flags of the three edge values.
// -----------------------------------------------------------------------------
package raster_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_DONE
  } state_t;

  function automatic int edge_width(input int coord_width);
    return 2 * coord_width + 2;
  endfunction

  localparam int WIDTH_DEFAULT = 8;
  localparam int EDGE_W        = 2 * WIDTH_DEFAULT + 2;

  typedef logic signed [EDGE_W-1:0] edge_t;

  // Counter-clockwise triangles (area > 0) need every edge >= 0.
  // Clockwise triangles (area < 0) need every edge <= 0.
  // Zero is inside for both windings, so pixels on a shared edge are drawn
  // by both neighbouring triangles.
  function automatic logic covered(input logic       area_neg,
                                   input logic [2:0] e_neg,
                                   input logic [2:0] e_zero);
    if (area_neg) begin
      return &(e_neg | e_zero);
    end
    return &(~e_neg);
  endfunction

endpackage

// File: rtl/edge_stepper.sv
// -----------------------------------------------------------------------------
// edge_stepper
// Incremental evaluator for one triangle edge function. It keeps the edge value
// at the current candidate and the value at the start of the current row.
//   clock, resetn : clock, synchronous active-low reset
//   load          : load init_val into both the current and row-start values
//   hold          : freeze all state (output stalled); below load in priority
//   step_x        : move one pixel right   (e += inc_x)
//   step_row      : move to the next row   (e = row_start + inc_row, and
//                                           row_start is updated the same way)
//   init_val      : edge value at (xmin, ymin)
//   inc_x         : -(Qy-Py)
//   inc_row       : (Qx-Px)
//   e             : edge value at the current candidate
// -----------------------------------------------------------------------------
module edge_stepper
  import raster_pkg::*;
#(
  parameter int EW = EDGE_W
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 load,
  input  logic                 hold,
  input  logic                 step_x,
  input  logic                 step_row,
  input  logic signed [EW-1:0] init_val,
  input  logic signed [EW-1:0] inc_x,
  input  logic signed [EW-1:0] inc_row,
  output logic signed [EW-1:0] e
);

  logic signed [EW-1:0] row_start;

  // NOTE: state registers use non-blocking assignments so that every flop in
  // the design samples pre-edge values, whatever order the blocks execute in.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      e         <= '0;
      row_start <= '0;
    end else if (load) begin
      e         <= init_val;
      row_start <= init_val;
    end else if (!hold) begin
      if (step_row) begin
        e         <= row_start + inc_row;
        row_start <= row_start + inc_row;
      end else if (step_x) begin
        e         <= e + inc_x;
      end
    end
  end

endmodule

// File: rtl/raster_triangle.sv
// -----------------------------------------------------------------------------
// raster_triangle
// Triangle rasteriser. It accepts one triangle per ready/valid handshake and
// clips its bounding box to the screen. It then scans the box row-major, one
// candidate per cycle, using three incremental edge functions. Covered pixels
// go out on a backpressured ready/valid stream. done pulses for one cycle when
// a triangle completes, including triangles that produce no pixels.
//
// Optional build macro: CULL_BACKFACE_EN. When it is defined, clockwise
// triangles (negative twice-area) are rejected during setup.
//
// Ports
//   clock, resetn          : clock, synchronous active-low reset
//   in_valid / in_ready    : triangle handshake (in_ready high only when idle)
//   ax, ay, bx, by, cx, cy : vertex coordinates, sampled on accept
//   colour                 : fill colour, sampled on accept
//   out_valid / out_ready  : pixel handshake
//   oX, oY, oColour        : pixel coordinate and colour
//   done                   : one-cycle end-of-triangle pulse
// -----------------------------------------------------------------------------
module raster_triangle
  import raster_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        ax,
  input  logic [WIDTH-1:0]        ay,
  input  logic [WIDTH-1:0]        bx,
  input  logic [WIDTH-1:0]        by,
  input  logic [WIDTH-1:0]        cx,
  input  logic [WIDTH-1:0]        cy,
  input  logic [COLOUR_WIDTH-1:0] colour,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        oX,
  output logic [WIDTH-1:0]        oY,
  output logic [COLOUR_WIDTH-1:0] oColour,
  output logic                    done
);

  localparam int EW = edge_width(WIDTH);
  localparam logic [WIDTH-1:0] X_LAST = WIDTH'(SCREEN_W - 1);
  localparam logic [WIDTH-1:0] Y_LAST = WIDTH'(SCREEN_H - 1);

  function automatic logic signed [EW-1:0] ext(input logic [WIDTH-1:0] v);
    return $signed({{(EW-WIDTH){1'b0}}, v});
  endfunction

  function automatic logic [WIDTH-1:0] min3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [WIDTH-1:0] max3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  state_t                  state;
  logic [WIDTH-1:0]        ax_r, ay_r, bx_r, by_r, cx_r, cy_r;
  logic [COLOUR_WIDTH-1:0] colour_r;
  logic [WIDTH-1:0]        xmin_r, xmax_r, ymax_r;
  logic [WIDTH-1:0]        x_cnt, y_cnt;
  logic                    area_neg_r;

  // Setup datapath. It works from the registered vertices, so the values it
  // produces are valid in S_SETUP. inc_x/inc_row stay valid for the whole scan.
  logic [WIDTH-1:0]     bb_xmin, bb_ymin, bb_xmax, bb_ymax;
  logic                 off_screen, area_zero, reject;
  logic signed [EW-1:0] area;
  logic signed [EW-1:0] vx [3];
  logic signed [EW-1:0] vy [3];
  logic signed [EW-1:0] d_x [3];
  logic signed [EW-1:0] d_y [3];
  logic signed [EW-1:0] e_init [3];
  logic signed [EW-1:0] e_inc_x [3];
  logic signed [EW-1:0] e_inc_row [3];
  logic signed [EW-1:0] e_val [3];

  // NOTE: every signal driven in always_comb is given a value on every path
  // (defaults first or full if/else), so no latch can be inferred.
  always_comb begin
    bb_xmin = min3(ax_r, bx_r, cx_r);
    bb_ymin = min3(ay_r, by_r, cy_r);
    bb_xmax = max3(ax_r, bx_r, cx_r);
    bb_ymax = max3(ay_r, by_r, cy_r);
    if (bb_xmax > X_LAST) bb_xmax = X_LAST;
    if (bb_ymax > Y_LAST) bb_ymax = Y_LAST;
    off_screen = (bb_xmin > X_LAST) || (bb_ymin > Y_LAST);

    vx[0] = ext(ax_r);  vy[0] = ext(ay_r);
    vx[1] = ext(bx_r);  vy[1] = ext(by_r);
    vx[2] = ext(cx_r);  vy[2] = ext(cy_r);

    // Edges a->b, b->c, c->a: P = v[i], Q = v[i+1 mod 3].
    for (int i = 0; i < 3; i++) begin
      d_x[i]       = vx[(i+1)%3] - vx[i];
      d_y[i]       = vy[(i+1)%3] - vy[i];
      e_inc_x[i]   = -d_y[i];
      e_inc_row[i] = d_x[i];
      e_init[i]    = d_x[i] * (ext(bb_ymin) - vy[i])
                   - d_y[i] * (ext(bb_xmin) - vx[i]);
    end

    // Twice-area is the a->b edge function evaluated at c.
    area      = d_x[0] * (vy[2] - vy[0]) - d_y[0] * (vx[2] - vx[0]);
    area_zero = (area == '0);
`ifdef CULL_BACKFACE_EN
    reject = area_zero || area[EW-1] || off_screen;
`else
    reject = area_zero || off_screen;
`endif
  end

  // Scan control. The scan advances only when the output register is free,
  // or is being drained in this same cycle.
  logic       advance, last_x, last_y, hit;
  logic       load_edges, hold_edges, step_x, step_row;
  logic [2:0] e_neg, e_zero;

  always_comb begin
    advance    = (state == S_SCAN) && (!out_valid || out_ready);
    last_x     = (x_cnt == xmax_r);
    last_y     = (y_cnt == ymax_r);
    load_edges = (state == S_SETUP);
    hold_edges = (state == S_SCAN) && !advance;
    step_x     = advance && !last_x;
    step_row   = advance && last_x && !last_y;
    for (int i = 0; i < 3; i++) begin
      e_neg[i]  = e_val[i][EW-1];
      e_zero[i] = (e_val[i] == '0);
    end
    hit = covered(area_neg_r, e_neg, e_zero);
  end

  for (genvar g = 0; g < 3; g++) begin : g_edge
    edge_stepper #(
      .EW (EW)
    ) u_edge (
      .clock    (clock),
      .resetn   (resetn),
      .load     (load_edges),
      .hold     (hold_edges),
      .step_x   (step_x),
      .step_row (step_row),
      .init_val (e_init[g]),
      .inc_x    (e_inc_x[g]),
      .inc_row  (e_inc_row[g]),
      .e        (e_val[g])
    );
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      oX         <= '0;
      oY         <= '0;
      oColour    <= '0;
      ax_r       <= '0;
      ay_r       <= '0;
      bx_r       <= '0;
      by_r       <= '0;
      cx_r       <= '0;
      cy_r       <= '0;
      colour_r   <= '0;
      xmin_r     <= '0;
      xmax_r     <= '0;
      ymax_r     <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      area_neg_r <= 1'b0;
    end else begin
      done <= 1'b0;
      // A pixel accepted downstream empties the register unless the scan
      // reloads it below in the same cycle.
      if (out_valid && out_ready) out_valid <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            ax_r     <= ax;
            ay_r     <= ay;
            bx_r     <= bx;
            by_r     <= by;
            cx_r     <= cx;
            cy_r     <= cy;
            colour_r <= colour;
            in_ready <= 1'b0;
            state    <= S_SETUP;
          end else begin
            // Also delays in_ready by one cycle after reset and after done.
            in_ready <= 1'b1;
          end
        end

        S_SETUP: begin
          xmin_r     <= bb_xmin;
          xmax_r     <= bb_xmax;
          ymax_r     <= bb_ymax;
          x_cnt      <= bb_xmin;
          y_cnt      <= bb_ymin;
          area_neg_r <= area[EW-1];
          state      <= reject ? S_DONE : S_SCAN;
        end

        S_SCAN: begin
          if (advance) begin
            if (hit) begin
              oX        <= x_cnt;
              oY        <= y_cnt;
              oColour   <= colour_r;
              out_valid <= 1'b1;
            end
            if (last_x && last_y) begin
              state <= S_DONE;
            end else if (last_x) begin
              x_cnt <= xmin_r;
              y_cnt <= y_cnt + 1'b1;
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          if (!out_valid || out_ready) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
